// File: rtl/disp_share_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | disp_share_arbiter_if -- requester, display-driver and status bundle   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface disp_share_arbiter_if;
  logic        req0;
  logic        req1;
  logic [31:0] frame0;
  logic [31:0] frame1;
  logic [2:0]  bright0;
  logic [2:0]  bright1;
  logic        drv_busy;
  logic        drv_start;
  logic [31:0] frame_o;
  logic [2:0]  bright_o;
  logic        owner;
  logic        grant0;
  logic        grant1;
  logic        err;

  modport slave (
    input  req0, req1, frame0, frame1, bright0, bright1, drv_busy,
    output drv_start, frame_o, bright_o, owner, grant0, grant1, err
  );

  modport master (
    output req0, req1, frame0, frame1, bright0, bright1, drv_busy,
    input  drv_start, frame_o, bright_o, owner, grant0, grant1, err
  );
endinterface
`default_nettype wire

// File: rtl/disp_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | disp_share_arbiter -- round-robin ownership of a shared TM1638 display |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module disp_share_arbiter #(
  parameter int unsigned DWELL_CYC = 50_000_000,
  parameter int unsigned ACK_TO    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  disp_share_arbiter_if.slave  bus
);
  localparam int unsigned ACK_W = $clog2(ACK_TO + 1);
  localparam int unsigned DW_W  = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam logic [ACK_W-1:0] ACK_LIMIT  = ACK_W'(ACK_TO);
  localparam logic [DW_W-1:0]  DWELL_LOAD = DW_W'(DWELL_CYC - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    DWELL     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      frame_q, frame_d;
  logic [2:0]       bright_q, bright_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             grant0_q, grant0_d;
  logic             grant1_q, grant1_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [DW_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic             winner;

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    bright_d    = bright_q;
    owner_d     = owner_q;
    last_d      = last_q;
    grant0_d    = 1'b0;
    grant1_d    = 1'b0;
    start_d     = 1'b0;
    err_d       = err_q;
    ack_cnt_d   = ack_cnt_q;
    dwell_cnt_d = dwell_cnt_q;
    // Contention goes to whoever was not served last; a lone request always wins.
    winner      = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          frame_d  = winner ? bus.frame1  : bus.frame0;
          bright_d = winner ? bus.bright1 : bus.bright0;
          owner_d  = winner;
          last_d   = winner;
          grant0_d = ~winner;
          grant1_d = winner;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (!bus.drv_busy) begin
          start_d   = 1'b1;
          ack_cnt_d = '0;
          state_d   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (bus.drv_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == ACK_LIMIT) begin
          err_d   = 1'b1;
          state_d = SEND;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.drv_busy) begin
          dwell_cnt_d = DWELL_LOAD;
          state_d     = DWELL;
        end
      end
      DWELL: begin
        if (dwell_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      frame_q     <= '0;
      bright_q    <= '0;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      grant0_q    <= 1'b0;
      grant1_q    <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
      ack_cnt_q   <= '0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      bright_q    <= bright_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      grant0_q    <= grant0_d;
      grant1_q    <= grant1_d;
      start_q     <= start_d;
      err_q       <= err_d;
      ack_cnt_q   <= ack_cnt_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign bus.drv_start = start_q;
  assign bus.frame_o   = frame_q;
  assign bus.bright_o  = bright_q;
  assign bus.owner     = owner_q;
  assign bus.grant0    = grant0_q;
  assign bus.grant1    = grant1_q;
  assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: doc/disp_share_arbiter.md
DISP_SHARE_ARBITER -- requirements
Module: disp_share_arbiter

Interface
REQ-001 The block SHALL have parameter DWELL_CYC, default 50_000_000, giving the minimum cycles a granted frame stays shown before re-arbitration (legal range >= 1).
REQ-002 The block SHALL have parameter ACK_TO, default 16, giving the cycles to wait for drv_busy after drv_start before retrying.
REQ-003 The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req0 / req1  in  1 each  level request from requester 0 / 1 for display ownership.
REQ-007 frame0 / frame1  in  32 each  eight 4-bit hex digits, digit0 in [3:0] to digit7 in [31:28].
REQ-008 bright0 / bright1  in  3 each  requested TM1638 brightness code.
REQ-009 drv_busy  in  1  high while the downstream TM1638 serial driver is transferring.
REQ-010 drv_start  out  1  one-cycle pulse telling the driver to send frame_o/bright_o.
REQ-011 frame_o  out  32  frame currently owned by the display.
REQ-012 bright_o  out  3  brightness currently owned by the display.
REQ-013 owner  out  1  index of the requester whose frame is in frame_o.
REQ-014 grant0 / grant1  out  1 each  one-cycle pulse: that requester's frame was captured.
REQ-015 err  out  1  sticky flag: at least one driver-ack timeout occurred.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, WAIT_ACK, WAIT_DONE, DWELL.
REQ-017 IDLE: no req -> stay; outputs hold last values.
REQ-018 IDLE with req: on that edge, capture winner's frame/bright into frame_o/bright_o, set owner, pulse matching grant for the next cycle, go SEND.
REQ-019 Arbitration SHALL be round-robin: both req high -> winner is the requester not in last_served; single req -> that requester wins.
REQ-020 last_served SHALL update to the winner at capture.
REQ-021 Requests SHALL be sampled only in IDLE; a req pulse that falls before IDLE is lost, with no grant.
REQ-022 SEND: drv_busy=0 -> drv_start=1 for exactly one cycle, clear ack counter, go WAIT_ACK; drv_busy=1 -> stay, drv_start=0.
REQ-023 WAIT_ACK: drv_busy=1 -> go WAIT_DONE.
REQ-024 WAIT_ACK: otherwise increment the ack counter; after ACK_TO cycles without drv_busy, set err=1 and return to SEND (retry, unbounded).
REQ-025 WAIT_DONE: drv_busy=0 -> load dwell counter with DWELL_CYC-1, go DWELL.
REQ-026 DWELL: decrement each cycle; at 0, go IDLE.
REQ-027 DWELL duration SHALL be exactly DWELL_CYC cycles, independent of req activity.
REQ-028 frame_o, bright_o and owner SHALL change only on capture in IDLE, never mid-transfer or mid-dwell.
REQ-029 Input frame changes after capture SHALL NOT affect frame_o until the next grant.
REQ-030 Minimum grant-to-grant spacing (driver acks in 1 cycle, busy for B cycles) SHALL be 1+1+1+B+DWELL_CYC cycles.
REQ-031 drv_start and both grants SHALL be registered outputs and never high in the same cycle.
REQ-032 Counters SHALL be sized by clog2 of their parameter and SHALL NOT wrap.

Reset
REQ-033 rst_n low SHALL immediately force state=IDLE, frame_o=0, bright_o=0, owner=0, last_served=1, grant0=grant1=0, drv_start=0, err=0, and all counters to 0.
REQ-034 Reset asserted mid-transfer or mid-dwell SHALL abort with no further drv_start; the first grant after release goes to req0 when both requests are high.
REQ-035 err SHALL clear only by reset.

Verification
REQ-036 Both req high after reset, frame0=32'h01234567, frame1=32'h89ABCDEF -> grant0 pulse, frame_o=32'h01234567, owner=0; after drv ack/done + DWELL_CYC cycles -> grant1, frame_o=32'h89ABCDEF.
REQ-037 DWELL_CYC=4, driver model busy 3 cycles after start, req0 held -> drv_start pulses spaced exactly 10 cycles, grant0 each cycle before drv_start.
REQ-038 drv_busy stuck low, ACK_TO=16 -> err=1 after 16 cycles in WAIT_ACK; drv_start re-pulses every 18 cycles; frame_o unchanged.
REQ-039 drv_busy high at entry to SEND -> drv_start withheld until drv_busy falls, then one pulse.
REQ-040 frame0 changed to 32'hFFFFFFFF during DWELL -> frame_o keeps old value until the next grant0.
REQ-041 rst_n pulsed low during WAIT_DONE -> all outputs at reset values within the same cycle; no drv_start until a new req is granted.
